// File: rtl/cvxif_instr_pkg.sv
// Shared CV-X-IF widths plus the group-issuer types: issue kinds, FSM states, result record.
// cvxif_pkg is the minimal local copy of the interface-level package; the instruction package builds on it.
package cvxif_pkg;
    localparam int unsigned X_ID_WIDTH = 4;
endpackage

package cvxif_instr_pkg;
    localparam int unsigned RESULT_WIDTH = 32;

    typedef enum logic [1:0] {
        KIND_FILL  = 2'd0,
        KIND_EXEC  = 2'd1,
        KIND_PICK  = 2'd2,
        KIND_FENCE = 2'd3
    } issue_kind_e;

    typedef enum logic {
        ST_IDLE       = 1'b0,
        ST_FENCE_WAIT = 1'b1
    } issuer_state_e;

    typedef struct packed {
        logic [RESULT_WIDTH-1:0]          data;
        logic [cvxif_pkg::X_ID_WIDTH-1:0] id;
        logic                             err;
    } x_result_t;
endpackage

// File: rtl/fifo_v3.sv
// Synchronous FIFO with the common_cells fifo_v3 interface; the head entry is always visible on data_o.
// Storage is not reset, only pointers and the fill count.
module fifo_v3 #(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 8,
    parameter type         dtype        = logic [DATA_WIDTH-1:0],
    parameter int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  testmode_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [ADDR_DEPTH-1:0] usage_o,
    input  dtype                  data_i,
    input  logic                  push_i,
    output dtype                  data_o,
    input  logic                  pop_i
);
    localparam logic [ADDR_DEPTH:0]   FULL_CNT = (ADDR_DEPTH + 1)'(DEPTH);
    localparam logic [ADDR_DEPTH-1:0] LAST_PTR = ADDR_DEPTH'(DEPTH - 1);

    logic [ADDR_DEPTH-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [ADDR_DEPTH:0]   cnt_q, cnt_d;
    dtype                  mem_q [DEPTH];
    logic                  do_push, do_pop;
    logic                  unused_testmode;

    assign unused_testmode = testmode_i;

    assign full_o  = (cnt_q == FULL_CNT);
    assign empty_o = (cnt_q == '0) && !(FALL_THROUGH && push_i);
    assign usage_o = cnt_q[ADDR_DEPTH-1:0];
    assign data_o  = (FALL_THROUGH && cnt_q == '0) ? data_i : mem_q[rd_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (do_push) wr_d = (wr_q == LAST_PTR) ? '0 : wr_q + 1'b1;
        if (do_pop)  rd_d = (rd_q == LAST_PTR) ? '0 : rd_q + 1'b1;
        if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
        else if (do_pop && !do_push) cnt_d = cnt_q - 1'b1;
        if (flush_i) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end
endmodule

// File: rtl/group_issuer.sv
// Bridges core issue/result handshakes onto a functional-unit group, buffering results in a FIFO.
// Credits (in-flight EXECs + buffered results) guarantee every accepted result-producing request has a slot.
//
// state         | meaning
// ST_IDLE       | requests accepted subject to credits and group busy
// ST_FENCE_WAIT | stall all issue until nothing is in flight and the FIFO is empty
module group_issuer
    import cvxif_instr_pkg::*;
#(
    parameter int unsigned X_ID_WIDTH       = cvxif_pkg::X_ID_WIDTH,
    parameter int unsigned inputWidth       = 32,
    parameter int unsigned outputWidth      = 32,
    parameter int unsigned opocdeWidth      = 8,
    parameter int unsigned inputIndexWidth  = 3,
    parameter int unsigned outputIndexWidth = 3,
    parameter int unsigned ResultDepth      = 4
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                issue_valid_i,
    output logic                                issue_ready_o,
    input  logic [1:0]                          issue_kind_i,
    input  logic [opocdeWidth-1:0]              issue_opcode_i,
    input  logic [X_ID_WIDTH-1:0]               issue_id_i,
    input  logic [((inputIndexWidth > outputIndexWidth) ? inputIndexWidth : outputIndexWidth)-1:0] issue_idx_i,
    input  logic [1:0][inputWidth-1:0]          issue_rs_i,
    output logic                                exec_o,
    output logic                                in_data_vld_o,
    output logic                                out_data_vld_o,
    output logic [opocdeWidth-1:0]              opcode_o,
    output logic [X_ID_WIDTH-1:0]               instr_id_o,
    output logic [inputIndexWidth-1:0]          in_idx_o,
    output logic [outputIndexWidth-1:0]         out_idx_o,
    output logic [1:0][inputWidth-1:0]          in_data_o,
    input  logic                                invalid_instr_i,
    input  logic                                busy_i,
    input  logic                                done_i,
    input  logic [outputWidth-1:0]              out_data_i,
    input  logic [X_ID_WIDTH-1:0]               instr_id_i,
    output logic                                result_valid_o,
    input  logic                                result_ready_i,
    output logic [outputWidth-1:0]              result_data_o,
    output logic [X_ID_WIDTH-1:0]               result_id_o,
    output logic                                result_err_o
);
    localparam int unsigned OutsW     = $clog2(ResultDepth + 1);
    localparam int unsigned CredW     = OutsW + 1;
    localparam int unsigned FifoAddrW = $clog2(ResultDepth);

    issuer_state_e        state_q, state_d;
    logic [OutsW-1:0]     outs_q, outs_d;
    issue_kind_e          kind;
    logic [CredW-1:0]     fifo_cnt, credits;
    logic                 has_room, accept, done_ok, err_push, fifo_push, fifo_pop;
    logic                 fifo_full, fifo_empty;
    logic [FifoAddrW-1:0] fifo_usage;
    x_result_t            push_res, head_res;

    assign kind       = issue_kind_e'(issue_kind_i);
    assign opcode_o   = issue_opcode_i;
    assign instr_id_o = issue_id_i;
    assign in_idx_o   = issue_idx_i[inputIndexWidth-1:0];
    assign out_idx_o  = issue_idx_i[outputIndexWidth-1:0];
    assign in_data_o  = issue_rs_i;

    // A full FIFO reports usage 0, so the count is rebuilt from the full flag.
    assign fifo_cnt = fifo_full ? CredW'(ResultDepth) : CredW'(fifo_usage);
    assign credits  = CredW'(outs_q) + fifo_cnt;
    assign has_room = credits < CredW'(ResultDepth);

    always_comb begin
        state_d       = state_q;
        issue_ready_o = 1'b0;
        if (state_q == ST_IDLE) begin
            if (invalid_instr_i && kind != KIND_FENCE) begin
                issue_ready_o = has_room;
            end else begin
                case (kind)
                    KIND_FILL:  issue_ready_o = 1'b1;
                    KIND_EXEC:  issue_ready_o = !busy_i && has_room;
                    KIND_PICK:  issue_ready_o = has_room;
                    KIND_FENCE: issue_ready_o = 1'b1;
                    default:    issue_ready_o = 1'b0;
                endcase
            end
            if (issue_valid_i && issue_ready_o && kind == KIND_FENCE) state_d = ST_FENCE_WAIT;
        end else if (outs_q == '0 && fifo_empty) begin
            state_d = ST_IDLE;
        end
    end

    assign accept         = issue_valid_i && issue_ready_o && !invalid_instr_i;
    assign exec_o         = accept && kind == KIND_EXEC;
    assign in_data_vld_o  = accept && kind == KIND_FILL;
    assign out_data_vld_o = accept && kind == KIND_PICK;
    assign err_push       = issue_valid_i && issue_ready_o && invalid_instr_i && kind != KIND_FENCE;
    assign done_ok        = done_i && outs_q != '0;

    always_comb begin
        outs_d = outs_q;
        if (exec_o && !done_ok)      outs_d = outs_q + 1'b1;
        else if (done_ok && !exec_o) outs_d = outs_q - 1'b1;
    end

    always_comb begin
        push_res = '{data: out_data_i, id: issue_id_i, err: 1'b0};
        if (done_ok)       push_res = '{data: out_data_i, id: instr_id_i, err: 1'b0};
        else if (err_push) push_res = '{data: '0, id: issue_id_i, err: 1'b1};
    end

    assign fifo_push = done_ok || err_push || out_data_vld_o;
    assign fifo_pop  = result_valid_o && result_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            outs_q  <= '0;
        end else begin
            state_q <= state_d;
            outs_q  <= outs_d;
        end
    end

    fifo_v3 #(
        .FALL_THROUGH (1'b0),
        .DATA_WIDTH   ($bits(x_result_t)),
        .DEPTH        (ResultDepth),
        .dtype        (x_result_t)
    ) i_result_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .flush_i    (1'b0),
        .testmode_i (1'b0),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .usage_o    (fifo_usage),
        .data_i     (push_res),
        .push_i     (fifo_push),
        .data_o     (head_res),
        .pop_i      (fifo_pop)
    );

    assign result_valid_o = !fifo_empty;
    assign result_data_o  = head_res.data;
    assign result_id_o    = head_res.id;
    assign result_err_o   = head_res.err;

    a_stray_done: assert property (@(posedge clk_i) disable iff (!rst_ni) !(done_i && outs_q == '0))
        else $error("done_i with no outstanding EXEC");
    a_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni) !(fifo_push && fifo_full))
        else $error("result push into full FIFO");
    a_push_clash: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(done_ok && (err_push || out_data_vld_o)))
        else $error("done_i collides with an issue-side result");
endmodule
